// File: rtl/step_phase_decoder_pkg.sv
// Shared phase types and decode helpers for the stepper phase-bus monitor.
// Legal bus patterns are {A1,B1,A2,B2}; everything else classifies as PH_BAD.
package step_phase_pkg;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH1,
        PH2,
        PH3,
        PH4,
        PH_BAD
    } phase_t;

    localparam logic [3:0] PAT_IDLE = 4'b0000;
    localparam logic [3:0] PAT_PH1  = 4'b1100;
    localparam logic [3:0] PAT_PH2  = 4'b0110;
    localparam logic [3:0] PAT_PH3  = 4'b0011;
    localparam logic [3:0] PAT_PH4  = 4'b1001;

    typedef struct packed {
        logic signed [1:0] delta;
        logic              diag;
    } step_t;

    function automatic phase_t classify(input logic [3:0] pat);
        case (pat)
            PAT_IDLE: classify = PH_IDLE;
            PAT_PH1:  classify = PH1;
            PAT_PH2:  classify = PH2;
            PAT_PH3:  classify = PH3;
            PAT_PH4:  classify = PH4;
            default:  classify = PH_BAD;
        endcase
    endfunction

    // PH1..PH4 are consecutive codes, so the modulo-4 distance gives the move.
    function automatic step_t step_of(input phase_t old_ph, input phase_t new_ph);
        logic [1:0] d;
        step_of.delta = 2'sd0;
        step_of.diag  = 1'b0;
        if ((old_ph inside {PH1, PH2, PH3, PH4}) && (new_ph inside {PH1, PH2, PH3, PH4})) begin
            d = 2'(new_ph - old_ph);
            case (d)
                2'd1:    step_of.delta = 2'sd1;
                2'd3:    step_of.delta = -2'sd1;
                2'd2:    step_of.diag  = 1'b1;
                default: ;
            endcase
        end
    endfunction

endpackage

// File: rtl/step_phase_decoder_if.sv
// Phase-bus monitor interface: stimulus side (master) and decoder side (slave).
// target/at_target exist only when STEP_PHASE_DECODER_TARGET_EN is defined.
interface step_phase_decoder_if #(
    parameter int unsigned POS_W = 14
);
    logic        [3:0]       phase_in;
    logic                    clr;
    logic signed [POS_W-1:0] position;
    logic                    dir;
    logic                    step_pulse;
    logic                    idle;
    logic                    settled;
    logic                    fault;
    logic        [7:0]       fault_count;
`ifdef STEP_PHASE_DECODER_TARGET_EN
    logic signed [POS_W-1:0] target;
    logic                    at_target;

    modport master (
        output phase_in, clr, target,
        input  position, dir, step_pulse, idle, settled, fault, fault_count, at_target
    );
    modport slave (
        input  phase_in, clr, target,
        output position, dir, step_pulse, idle, settled, fault, fault_count, at_target
    );
`else
    modport master (
        output phase_in, clr,
        input  position, dir, step_pulse, idle, settled, fault, fault_count
    );
    modport slave (
        input  phase_in, clr,
        output position, dir, step_pulse, idle, settled, fault, fault_count
    );
`endif
endinterface

// File: rtl/step_phase_decoder_filter.sv
// Synchroniser plus debounce for the phase bus; emits the accepted pattern and a
// one-cycle accept strobe (BAD patterns strobe but never become the accepted pattern).
module phase_filter
    import step_phase_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] phase_i,
    output logic [3:0] acc_pat_o,
    output logic [3:0] new_pat_o,
    output logic       accept_o
);
    localparam int unsigned      CNT_W   = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [3:0]                  cand_q, cand_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [3:0]                  acc_q, acc_d;
    logic                        hit_q, hit_d;
    logic [3:0]                  synced;
    logic                        accept;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], phase_i};
    assign synced = sync_q[SYNC_STAGES-1];

    // hit marks only the cycle the count first reaches the limit, so a held BAD
    // pattern (never stored as accepted) raises a single event.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        if (synced != cand_q) begin
            cand_d = synced;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        hit_d  = (cnt_d == CNT_MAX) && ((synced != cand_q) || (cnt_q != CNT_MAX));
        accept = hit_q && (cand_q != acc_q);
        if (accept && (classify(cand_q) != PH_BAD)) begin
            acc_d = cand_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            hit_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            hit_q  <= hit_d;
        end
    end

    assign acc_pat_o = acc_q;
    assign new_pat_o = cand_q;
    assign accept_o  = accept;

endmodule

// File: rtl/step_phase_decoder.sv
// Full-step phase-bus decoder: position, direction, step pulses, fault tracking.
// Define STEP_PHASE_DECODER_TARGET_EN to add the target comparator (at_target).
module step_phase_decoder
    import step_phase_pkg::*;
#(
    parameter int unsigned POS_W         = 14,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES = 1000000
) (
    input logic                clk,
    input logic                reset,
    step_phase_decoder_if.slave bus
);
    localparam int unsigned      SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SET_MAX = SET_W'(SETTLE_CYCLES);

    logic [3:0] acc_pat, new_pat;
    logic       accept;
    phase_t     old_ph, new_ph;
    step_t      st;
    logic       step_ev, fault_ev;

    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    dir_q, dir_d;
    logic                    pulse_q, pulse_d;
    logic                    fault_q, fault_d;
    logic [7:0]              fcnt_q, fcnt_d;
    logic [SET_W-1:0]        settle_q, settle_d;

    phase_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .phase_i  (bus.phase_in),
        .acc_pat_o(acc_pat),
        .new_pat_o(new_pat),
        .accept_o (accept)
    );

    always_comb begin
        old_ph   = classify(acc_pat);
        new_ph   = classify(new_pat);
        st       = step_of(old_ph, new_ph);
        step_ev  = accept && (st.delta != 2'sd0);
        fault_ev = accept && ((new_ph == PH_BAD) || st.diag);

        pos_d    = pos_q;
        dir_d    = dir_q;
        pulse_d  = 1'b0;
        fault_d  = fault_q;
        fcnt_d   = fcnt_q;
        settle_d = settle_q;

        // clr wins: a coincident step or fault event is dropped entirely.
        if (bus.clr) begin
            pos_d   = '0;
            fault_d = 1'b0;
            fcnt_d  = '0;
        end else begin
            if (step_ev) begin
                pos_d   = (st.delta == 2'sd1) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                dir_d   = (st.delta == 2'sd1);
                pulse_d = 1'b1;
            end
            if (fault_ev) begin
                fault_d = 1'b1;
                if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
            end
        end

        if (accept) begin
            settle_d = '0;
        end else if (settle_q != SET_MAX) begin
            settle_d = settle_q + SET_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q    <= '0;
            dir_q    <= 1'b0;
            pulse_q  <= 1'b0;
            fault_q  <= 1'b0;
            fcnt_q   <= '0;
            settle_q <= '0;
        end else begin
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            pulse_q  <= pulse_d;
            fault_q  <= fault_d;
            fcnt_q   <= fcnt_d;
            settle_q <= settle_d;
        end
    end

    assign bus.position    = pos_q;
    assign bus.dir         = dir_q;
    assign bus.step_pulse  = pulse_q;
    assign bus.idle        = (acc_pat == PAT_IDLE);
    assign bus.settled     = (settle_q == SET_MAX);
    assign bus.fault       = fault_q;
    assign bus.fault_count = fcnt_q;

`ifdef STEP_PHASE_DECODER_TARGET_EN
    logic at_target_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            at_target_q <= 1'b0;
        end else begin
            at_target_q <= (pos_q == bus.target) && (settle_q == SET_MAX);
        end
    end

    assign bus.at_target = at_target_q;
`endif

endmodule
